// File: rtl/operand_pair_sequencer.sv
// operand_pair_sequencer
//   Turns one matched block (packed dense index pairs + counts) into a stream
//   of (activation address, weight address) beats, one per cycle, into the
//   compressed operand buffers. Running base pointers advance by the block's
//   nonzero counts and return to zero after the final block of a dot product.
//
// Ports
//   clock, resetn              clock, asynchronous active-low reset
//   in_valid / in_ready        block handshake (in_ready only in IDLE)
//   in_indicesA / in_indicesW  packed dense indices, entry k at [(k+1)*IW-1 -: IW]
//   in_pairCount               valid pairs in the block (clamped to BITMASK_LENGTH)
//   in_countA / in_countW      nonzero counts used to advance the bases
//   in_last                    final block of the dot product
//   out_valid / out_ready      beat handshake
//   out_addrA / out_addrW      compressed-buffer addresses
//   out_null                   beat carries no pair (empty final block)
//   out_last                   final beat of the dot product
//   busy                       sequencer is not idle
module operand_pair_sequencer #(
  parameter int BITMASK_LENGTH   = 8,
  parameter int INDEX_BITWIDTH   = 3,
  parameter int COUNT_BITWIDTH   = 4,
  parameter int POINTER_BITWIDTH = 12
) (
  input  logic                                     clock,
  input  logic                                     resetn,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [BITMASK_LENGTH*INDEX_BITWIDTH-1:0] in_indicesA,
  input  logic [BITMASK_LENGTH*INDEX_BITWIDTH-1:0] in_indicesW,
  input  logic [COUNT_BITWIDTH-1:0]                in_pairCount,
  input  logic [COUNT_BITWIDTH-1:0]                in_countA,
  input  logic [COUNT_BITWIDTH-1:0]                in_countW,
  input  logic                                     in_last,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [POINTER_BITWIDTH-1:0]              out_addrA,
  output logic [POINTER_BITWIDTH-1:0]              out_addrW,
  output logic                                     out_null,
  output logic                                     out_last,
  output logic                                     busy
);

  localparam logic [COUNT_BITWIDTH-1:0] MAX_PAIRS = COUNT_BITWIDTH'(BITMASK_LENGTH);

  typedef enum logic [1:0] {IDLE, EMIT, NULL} state_t;

  state_t state, state_next;

  logic [BITMASK_LENGTH-1:0][INDEX_BITWIDTH-1:0] held_idx_a, held_idx_w;
  logic [COUNT_BITWIDTH-1:0]   held_pairs, held_count_a, held_count_w;
  logic                        held_last;
  logic [INDEX_BITWIDTH-1:0]   k;
  logic [POINTER_BITWIDTH-1:0] base_a, base_w;

  logic                      accept;
  logic [COUNT_BITWIDTH-1:0] pairs_clamped;
  logic                      last_pair;

  // in_ready is decoded purely from the state register.
  assign in_ready      = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = in_valid && in_ready;
  assign pairs_clamped = (in_pairCount > MAX_PAIRS) ? MAX_PAIRS : in_pairCount;
  assign last_pair     = (COUNT_BITWIDTH'(k) == held_pairs - COUNT_BITWIDTH'(1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every output and next-state signal gets a default before the case,
  // otherwise an unassigned path would infer a latch.
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_null   = 1'b0;
    out_last   = 1'b0;
    out_addrA  = '0;
    out_addrW  = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (pairs_clamped != '0) state_next = EMIT;
          else if (in_last)        state_next = NULL;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_addrA = base_a + POINTER_BITWIDTH'(held_idx_a[k]);
        out_addrW = base_w + POINTER_BITWIDTH'(held_idx_w[k]);
        out_last  = held_last && last_pair;
        if (out_ready && last_pair) state_next = IDLE;
      end
      NULL: begin
        out_valid = 1'b1;
        out_null  = 1'b1;
        out_last  = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pair cursor and running bases.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      k      <= '0;
      base_a <= '0;
      base_w <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            k <= '0;
            // An empty non-final block contributes only to the bases.
            if (pairs_clamped == '0 && !in_last) begin
              base_a <= base_a + POINTER_BITWIDTH'(in_countA);
              base_w <= base_w + POINTER_BITWIDTH'(in_countW);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (!last_pair) begin
              k <= k + 1'b1;
            end else if (held_last) begin
              base_a <= '0;
              base_w <= '0;
            end else begin
              base_a <= base_a + POINTER_BITWIDTH'(held_count_a);
              base_w <= base_w + POINTER_BITWIDTH'(held_count_w);
            end
          end
        end
        NULL: begin
          if (out_ready) begin
            base_a <= '0;
            base_w <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the holding registers are deliberately not reset; they are only
  // observed in EMIT, which is reachable only after a capture fills them.
  always_ff @(posedge clock) begin
    if (accept) begin
      held_idx_a   <= in_indicesA;
      held_idx_w   <= in_indicesW;
      held_pairs   <= pairs_clamped;
      held_count_a <= in_countA;
      held_count_w <= in_countW;
      held_last    <= in_last;
    end
  end

endmodule

// File: tb/tb_operand_pair_sequencer.sv
module tb_operand_pair_sequencer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_indicesA, in_indicesW;
  logic [3:0]  in_pairCount, in_countA, in_countW;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_addrA, out_addrW;
  logic        out_null, out_last, busy;

  int checks = 0;
  int errors = 0;

  operand_pair_sequencer dut (
    .clock        (clock),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_indicesA  (in_indicesA),
    .in_indicesW  (in_indicesW),
    .in_pairCount (in_pairCount),
    .in_countA    (in_countA),
    .in_countW    (in_countW),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addrA    (out_addrA),
    .out_addrW    (out_addrW),
    .out_null     (out_null),
    .out_last     (out_last),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Packs up to two entries into slots 0 and 1, remaining slots zero.
  function automatic logic [23:0] pk(input logic [2:0] e0, input logic [2:0] e1);
    pk = {18'b0, e1, e0};
  endfunction

  // Called just after a falling edge; presents the block for one rising edge.
  task automatic send(input logic [23:0] ia, input logic [23:0] iw, input logic [3:0] pc,
                      input logic [3:0] ca, input logic [3:0] cw, input logic last);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid     = 1'b1;
    in_indicesA  = ia;
    in_indicesW  = iw;
    in_pairCount = pc;
    in_countA    = ca;
    in_countW    = cw;
    in_last      = last;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Checks the beat currently presented, then lets it handshake (out_ready=1).
  task automatic beat(input string tag, input int a, input int w, input logic last, input logic nul);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_addrA"}, 32'(out_addrA), 32'(a));
    check({tag, "_addrW"}, 32'(out_addrW), 32'(w));
    check({tag, "_last"},  32'(out_last),  32'(last));
    check({tag, "_null"},  32'(out_null),  32'(nul));
    @(negedge clock);
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_indicesA = '0; in_indicesW = '0; in_pairCount = '0;
    in_countA = '0; in_countW = '0; in_last = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_null",  32'(out_null),  32'd0);
    check("rst_addrA",     32'(out_addrA), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Two-block dot product.
    send(pk(0, 3), pk(1, 2), 4'd2, 4'd5, 4'd4, 1'b0);
    check("b1_busy", 32'(busy), 32'd1);
    check("b1_in_ready", 32'(in_ready), 32'd0);
    beat("b1_beat0", 0, 1, 1'b0, 1'b0);
    beat("b1_beat1", 3, 2, 1'b0, 1'b0);
    send(pk(0, 0), pk(0, 0), 4'd1, 4'd1, 4'd2, 1'b1);
    beat("b2_beat0", 5, 4, 1'b1, 1'b0);
    check("b2_idle_after", 32'(out_valid), 32'd0);

    // Back-pressure on beat 0; bases start at 0 after the last block.
    out_ready = 1'b0;
    send(pk(0, 3), pk(1, 2), 4'd2, 4'd5, 4'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_addrA", 32'(out_addrA), 32'd0);
      check("bp_hold_addrW", 32'(out_addrW), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    beat("bp_beat0", 0, 1, 1'b0, 1'b0);
    check("bp_in_ready_beat1", 32'(in_ready), 32'd0);
    beat("bp_beat1", 3, 2, 1'b0, 1'b0);
    check("bp_in_ready_after", 32'(in_ready), 32'd1);

    // Empty final block (bases currently 5,4): one null beat, bases cleared.
    send(24'd0, 24'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("null_busy", 32'(busy), 32'd1);
    beat("null_beat", 0, 0, 1'b1, 1'b1);
    send(pk(0, 0), pk(0, 0), 4'd1, 4'd0, 4'd0, 1'b1);
    beat("after_null", 0, 0, 1'b1, 1'b0);

    // Empty non-final block only moves the bases.
    send(24'd0, 24'd0, 4'd0, 4'd3, 4'd2, 1'b0);
    check("empty_no_beat", 32'(out_valid), 32'd0);
    check("empty_in_ready", 32'(in_ready), 32'd1);
    send(pk(1, 0), pk(0, 0), 4'd1, 4'd1, 4'd1, 1'b1);
    beat("empty_then", 4, 2, 1'b1, 1'b0);

    // Wrap: 511*8 + 6 = 4094, then index 3 -> 4097 mod 4096 = 1.
    for (int i = 0; i < 511; i++) send(24'd0, 24'd0, 4'd0, 4'd8, 4'd0, 1'b0);
    send(24'd0, 24'd0, 4'd0, 4'd6, 4'd0, 1'b0);
    send(pk(3, 0), pk(0, 0), 4'd1, 4'd1, 4'd1, 1'b1);
    beat("wrap", 1, 0, 1'b1, 1'b0);

    // pairCount above BITMASK_LENGTH clamps to 8 beats.
    send({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 24'd0, 4'd12, 4'd8, 4'd8, 1'b1);
    for (int i = 0; i < 8; i++) beat("clamp", i, 0, (i == 7), 1'b0);
    check("clamp_done_valid", 32'(out_valid), 32'd0);
    check("clamp_done_in_ready", 32'(in_ready), 32'd1);

    // Reset mid-emission with nonzero bases (5,4) drops everything.
    send(pk(0, 3), pk(1, 2), 4'd2, 4'd5, 4'd4, 1'b0);
    beat("pre_rst0", 0, 1, 1'b0, 1'b0);
    beat("pre_rst1", 3, 2, 1'b0, 1'b0);
    send(pk(0, 3), pk(1, 2), 4'd2, 4'd5, 4'd4, 1'b0);
    beat("mid_beat0", 5, 5, 1'b0, 1'b0);
    check("mid_beat1_valid", 32'(out_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_busy",      32'(busy),      32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    send(pk(2, 0), pk(1, 0), 4'd1, 4'd1, 4'd1, 1'b1);
    beat("post_rst", 2, 1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_pair_sequencer.md
Name: operand_pair_sequencer

Overview:
- Sits between the 8-bit operand matcher and the PE MAC/operand-buffer read ports.
- Accepts one matched block per handshake: packed dense pair indices, pair count, and per-block nonzero counts of activation and weight.
- Emits one (activation address, weight address) pair per cycle into the compressed operand buffers.
- Keeps running base pointers across the blocks of one dot product and marks its end.

Parameters:
BITMASK_LENGTH, 8, lanes per block (must match the matcher).
INDEX_BITWIDTH, 3, width of one packed index, log2(BITMASK_LENGTH).
COUNT_BITWIDTH, 4, width of the count fields, able to hold 0..BITMASK_LENGTH.
POINTER_BITWIDTH, 12, width of the compressed-buffer address.

Ports:
clock  in  1  system clock.
resetn  in  1  asynchronous active-low reset.
in_valid  in  1  block valid.
in_ready  out  1  block accepted when in_valid && in_ready.
in_indicesA  in  BITMASK_LENGTH*INDEX_BITWIDTH  packed dense activation indices; entry k at bits [(k+1)*IW-1 -: IW].
in_indicesW  in  BITMASK_LENGTH*INDEX_BITWIDTH  packed dense weight indices, same packing.
in_pairCount  in  COUNT_BITWIDTH  number of valid pairs in the block.
in_countA  in  COUNT_BITWIDTH  popcount of the activation bitmask.
in_countW  in  COUNT_BITWIDTH  popcount of the weight bitmask.
in_last  in  1  block is the final one of the dot product.
out_valid  out  1  pair valid.
out_ready  in  1  consumer ready.
out_addrA  out  POINTER_BITWIDTH  activation buffer address.
out_addrW  out  POINTER_BITWIDTH  weight buffer address.
out_null  out  1  beat carries no pair; consumer does not MAC.
out_last  out  1  final beat of the dot product.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync deassert by the clock):
  - state=IDLE; baseA=baseW=0; k=0.
  - All outputs 0 except in_ready=1.
  - Reset mid-emission drops the current block.
- States: IDLE, EMIT, NULL.
- in_ready is 1 only in IDLE and is decoded from the state register. No combinational path from in_valid or out_ready to in_ready.
- Accept in IDLE: capture indices, counts and in_last into holding registers; k=0. Next state:
  - pairCount>0 -> EMIT.
  - pairCount==0 && in_last -> NULL.
  - pairCount==0 && !in_last -> stay IDLE; baseA+=countA, baseW+=countW at the same edge.
- EMIT:
  - out_valid=1.
  - out_addrA = baseA + zero-extended indicesA[k]; out_addrW likewise with baseW and indicesW[k].
  - out_null=0; out_last = held_last && (k==pairCount-1).
  - Outputs are driven from registers only and hold stable while out_valid && !out_ready.
- Handshake in EMIT with k<pairCount-1: k++.
- Handshake in EMIT with k==pairCount-1: go to IDLE and update the bases:
  - held_last=1 -> baseA=baseW=0;
  - otherwise -> baseA+=countA, baseW+=countW.
- NULL:
  - out_valid=1, out_null=1, out_last=1, addresses=0.
  - On handshake: bases cleared, go to IDLE.
- Latency: first out_valid in the cycle after acceptance.
- Throughput: pairCount+1 cycles per nonempty block with out_ready held high.
- Arithmetic: pointer addition is modulo 2^POINTER_BITWIDTH (wrap, no flag).
- in_pairCount > BITMASK_LENGTH is a protocol violation; it is clamped to BITMASK_LENGTH at capture.
- in_countA/in_countW are not checked against pairCount.
- Holding registers change only on an accepted handshake.

Test Plan:
- Block 1: indicesA entries {0,3}, indicesW entries {1,2}, pairCount=2, countA=5, countW=4, last=0, out_ready=1 -> beats (0,1),(3,2), out_last=0 on both.
  - Block 2: entries {0},{0}, pairCount=1, countA=1, countW=2, last=1 -> beat (5,4) with out_last=1; the next block's base returns to 0.
- Back-pressure: Block 1 with out_ready low for 3 cycles on beat 0 -> out_addrA/out_addrW stay (0,1) for those cycles; in_ready stays 0 until after beat 1.
- Empty block: pairCount=0, countA=3, countW=2, last=0, then block entries {1},{0}, pairCount=1, last=1 -> no beat for the first block; the single beat is (4,2), out_last=1.
- Empty last block: pairCount=0, last=1 -> one beat with out_null=1, out_last=1; bases read 0 afterwards.
- Wrap: preload baseA=4094 via repeated empty blocks, then entry {3} -> out_addrA=1.
- Reset mid-EMIT: assert resetn=0 during beat 1 of Block 1 -> out_valid=0, in_ready=1, busy=0 immediately. After release, a new block starts at bases 0.
